// File: rtl/fifo_rd_sched.sv
`timescale 1ns/1ps
// fifo_rd_sched
//   Read-side scheduler for a FIFO with an optional output register.
//   Arbitrates NREQ requesters round-robin. A grant runs a burst of up to
//   BURST_MAX reads, then drains the read pipeline before the next grant.
//   Returned data is tagged with the index of the requester that owns it.
//
// Ports
//   RDCLK    in   read clock, all state updates on its rising edge
//   RST      in   asynchronous active-low reset
//   req      in   per-requester read request (level)
//   EMPTY    in   FIFO empty flag
//   RDERR    in   FIFO read-error flag
//   DO       in   FIFO data output {DOP, DO}
//   RDEN     out  FIFO read enable
//   REGCE    out  FIFO output-register clock enable
//   gnt      out  one-hot grant (registered)
//   rd_valid out  rd_data / rd_tag valid
//   rd_data  out  FIFO data passed through
//   rd_tag   out  requester index owning rd_data
//   busy     out  scheduler not idle
//   err_cnt  out  saturating count of RDERR cycles
module fifo_rd_sched #(
    parameter int NREQ      = 4,
    parameter int DO_REG    = 1,
    parameter int BURST_MAX = 8
) (
    input  logic            RDCLK,
    input  logic            RST,
    input  logic [NREQ-1:0] req,
    input  logic            EMPTY,
    input  logic            RDERR,
    input  logic [35:0]     DO,
    output logic            RDEN,
    output logic            REGCE,
    output logic [NREQ-1:0] gnt,
    output logic            rd_valid,
    output logic [35:0]     rd_data,
    output logic [1:0]      rd_tag,
    output logic            busy,
    output logic [7:0]      err_cnt
);

    localparam int          DEPTH   = (DO_REG != 0) ? 2 : 1;
    localparam logic [4:0]  LP_BMAX = 5'(BURST_MAX);
    localparam logic [1:0]  LP_LAST = 2'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [1:0]        r_cur;
    logic [1:0]        r_rr_ptr;
    logic [3:0]        r_cnt;
    logic [NREQ-1:0]   r_gnt;
    logic [7:0]        r_err_cnt;

    logic [DEPTH-1:0]  r_pv;
    logic [1:0]        r_pt [DEPTH];

    logic              w_start;
    logic              w_pick_ok;
    logic [1:0]        w_pick;
    int unsigned       w_k;
    logic [4:0]        w_cnt_sum;
    logic              w_cnt_lt;
    logic              w_burst_done;
    logic              w_pending;
    logic [1:0]        w_rr_nxt;

    // Round-robin pick: first set request at or after r_rr_ptr, wrapping.
    always_comb begin
        w_pick_ok = 1'b0;
        w_pick    = '0;
        w_k       = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_k = (32'(r_rr_ptr) + i) % NREQ;
            if (!w_pick_ok && req[w_k]) begin
                w_pick_ok = 1'b1;
                w_pick    = w_k[1:0];
            end
        end
    end

    assign w_start      = w_pick_ok && !EMPTY;
    assign w_cnt_lt     = ({1'b0, r_cnt} < LP_BMAX);
    assign w_cnt_sum    = {1'b0, r_cnt} + {4'd0, RDEN};
    assign w_burst_done = !req[r_cur] || EMPTY || (w_cnt_sum == LP_BMAX);
    assign w_pending    = |r_pv;
    assign w_rr_nxt     = (r_cur == LP_LAST) ? 2'd0 : r_cur + 2'd1;

    // State register
    always_ff @(posedge RDCLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_start)      w_state_nxt = ST_BURST;
            ST_BURST: if (w_burst_done) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (!w_pending)   w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        RDEN = 1'b0;
        busy = (r_state != ST_IDLE);
        if (r_state == ST_BURST) begin
            RDEN = req[r_cur] && !EMPTY && w_cnt_lt;
        end
    end

    // Grant / burst bookkeeping
    always_ff @(posedge RDCLK or negedge RST) begin
        if (!RST) begin
            r_cur    <= '0;
            r_gnt    <= '0;
            r_cnt    <= '0;
            r_rr_ptr <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_cur <= w_pick;
                        r_gnt <= NREQ'(1) << w_pick;
                        r_cnt <= '0;
                    end
                end
                ST_BURST: begin
                    if (RDEN) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_DRAIN: begin
                    if (!w_pending) begin
                        r_gnt    <= '0;
                        r_rr_ptr <= w_rr_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read pipeline: (valid, tag) pairs, one stage per cycle of FIFO latency.
    always_ff @(posedge RDCLK or negedge RST) begin
        if (!RST) begin
            r_pv <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_pt[i] <= '0;
            end
        end else begin
            r_pv[0] <= RDEN;
            r_pt[0] <= r_cur;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pt[i] <= r_pt[i-1];
            end
        end
    end

    // Output register is clocked exactly when the latch stage holds a read.
    generate
        if (DO_REG != 0) begin : g_regce
            assign REGCE = r_pv[0];
        end else begin : g_noreg
            assign REGCE = 1'b1;
        end
    endgenerate

    // Saturating read-error counter
    always_ff @(posedge RDCLK or negedge RST) begin
        if (!RST) begin
            r_err_cnt <= '0;
        end else if (RDERR && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign gnt      = r_gnt;
    assign rd_valid = r_pv[DEPTH-1];
    assign rd_tag   = r_pt[DEPTH-1];
    assign rd_data  = DO;
    assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_fifo_rd_sched.sv
`timescale 1ns/1ps
// Testbench for fifo_rd_sched: directed scenarios with a FIFO model,
// a scoreboard of expected (tag, data) and a decoupled output monitor.
module tb_fifo_rd_sched;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (DO_REG = 1)
    logic        rst_n;
    logic [3:0]  req;
    logic        empty;
    logic        rderr;
    logic [35:0] do_w = '0;
    logic        rden, regce, rd_valid, busy;
    logic [3:0]  gnt;
    logic [35:0] rd_data;
    logic [1:0]  rd_tag;
    logic [7:0]  err_cnt;

    fifo_rd_sched #(.NREQ(4), .DO_REG(1), .BURST_MAX(8)) dut (
        .RDCLK(clk), .RST(rst_n), .req(req), .EMPTY(empty), .RDERR(rderr),
        .DO(do_w), .RDEN(rden), .REGCE(regce), .gnt(gnt),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_tag(rd_tag),
        .busy(busy), .err_cnt(err_cnt)
    );

    // Second DUT (DO_REG = 0) in a free-running environment
    logic [3:0]  req0;
    logic        empty0;
    logic        rderr0;
    logic [35:0] do0;
    logic        rden0, regce0, rd_valid0, busy0;
    logic [3:0]  gnt0;
    logic [35:0] rd_data0;
    logic [1:0]  rd_tag0;
    logic [7:0]  err_cnt0;
    int unsigned cyc = 0;

    fifo_rd_sched #(.NREQ(4), .DO_REG(0), .BURST_MAX(8)) dut0 (
        .RDCLK(clk), .RST(rst_n), .req(req0), .EMPTY(empty0), .RDERR(rderr0),
        .DO(do0), .RDEN(rden0), .REGCE(regce0), .gnt(gnt0),
        .rd_valid(rd_valid0), .rd_data(rd_data0), .rd_tag(rd_tag0),
        .busy(busy0), .err_cnt(err_cnt0)
    );

    always @(posedge clk) cyc <= cyc + 1;
    assign req0   = 4'b0101;
    assign empty0 = ((cyc % 7) == 3);
    assign rderr0 = 1'b0;
    assign do0    = {4'h0, cyc};

    // FIFO model: word k holds mkword(k); EMPTY when all written words read.
    int unsigned wr_total = 0;
    int unsigned rd_total = 0;
    logic [35:0] fifo_latch = '0;

    function automatic logic [35:0] mkword(input int unsigned k);
        return {4'hA, k};
    endfunction

    assign empty = (wr_total == rd_total);

    always @(posedge clk) begin
        if (rden) begin
            fifo_latch <= mkword(rd_total);
            rd_total   <= rd_total + 1;
        end
        if (regce) do_w <= fifo_latch;
    end

    // Expected latency: rd_valid is RDEN delayed by 1 + DO_REG cycles.
    logic h0, h1, g0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h0 <= 1'b0; h1 <= 1'b0; g0 <= 1'b0;
        end else begin
            h0 <= rden; h1 <= h0; g0 <= rden0;
        end
    end

    // Scoreboard
    typedef struct packed {
        logic [1:0]  tag;
        logic [35:0] data;
    } exp_t;
    exp_t        sb[$];
    int unsigned exp_rd = 0;
    int          n_cmp  = 0;
    int          n_bad  = 0;
    int unsigned rden_seen = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: cycle budget expired", nm);
    endtask

    task automatic push_exp(input logic [1:0] tag, input int unsigned n);
        exp_t e;
        for (int unsigned i = 0; i < n; i++) begin
            e.tag  = tag;
            e.data = mkword(exp_rd);
            exp_rd++;
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rden) rden_seen++;
    endtask

    // Waits for one grant to become busy and return to idle; gnt must hold.
    task automatic burst_wait(input string nm, input logic [3:0] exp_gnt);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (busy) begin
                seen = 1'b1;
                chk({nm, "_gnt_hold"}, 64'(gnt), 64'(exp_gnt));
            end else if (seen) begin
                return;
            end
        end
        timeout_fail(nm);
    endtask

    // Monitor: compares on every presented output, independent of stimulus.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            chk("latency_valid", 64'(rd_valid), 64'(h1));
            if (rd_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rd_valid: actual tag=%0d data=%0h required none", rd_tag, rd_data);
                end else begin
                    e = sb.pop_front();
                    chk("rd_tag", 64'(rd_tag), 64'(e.tag));
                    chk("rd_data", 64'(rd_data), 64'(e.data));
                end
            end
            if (rden) chk("rden_while_empty", 64'(empty), 64'd0);
            chk("latency_valid_doreg0", 64'(rd_valid0), 64'(g0));
            chk("regce_doreg0", 64'(regce0), 64'd1);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [3:0] prev;
        logic [3:0] order [5];
        int         ng;
        bit         done;

        rst_n = 1'b0; req = '0; rderr = 1'b0;
        #2;
        chk("rst_gnt",      64'(gnt),      64'd0);
        chk("rst_rden",     64'(rden),     64'd0);
        chk("rst_regce",    64'(regce),    64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_tag",   64'(rd_tag),   64'd0);
        chk("rst_busy",     64'(busy),     64'd0);
        chk("rst_err_cnt",  64'(err_cnt),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single burst from requester 0, FIFO holding 20 words
        rden_seen = 0;
        wr_total += 20;
        push_exp(2'd0, 8);
        req = 4'b0001;
        burst_wait("t1", 4'b0001);
        req = '0;
        chk("t1_rden_pulses", 64'(rden_seen), 64'd8);
        chk("t1_gnt_cleared", 64'(gnt), 64'd0);
        chk("t1_rr_ptr", 64'(dut.r_rr_ptr), 64'd1);
        chk("t1_sb_empty", 64'(sb.size()), 64'd0);

        // Reset restarts arbitration from index 0
        rst_n = 1'b0;
        #1;
        chk("rst2_rr_ptr", 64'(dut.r_rr_ptr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round robin with all requesters, 40 words available in total
        rden_seen = 0;
        wr_total += 28;
        push_exp(2'd0, 8); push_exp(2'd1, 8); push_exp(2'd2, 8);
        push_exp(2'd3, 8); push_exp(2'd0, 8);
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        prev = '0; ng = 0; done = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (gnt != 4'b0000 && gnt != prev) begin
                if (ng < 5) chk("t2_grant_order", 64'(gnt), 64'(order[ng]));
                ng++;
            end
            prev = gnt;
            if (ng >= 5 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        req = '0;
        if (!done) timeout_fail("t2_round_robin");
        chk("t2_grants", 64'(ng), 64'd5);
        chk("t2_rden_pulses", 64'(rden_seen), 64'd40);
        chk("t2_sb_empty", 64'(sb.size()), 64'd0);

        // FIFO runs empty mid-burst: 3 words for requester 2
        rden_seen = 0;
        wr_total += 3;
        push_exp(2'd2, 3);
        req = 4'b0100;
        burst_wait("t3", 4'b0100);
        req = '0;
        chk("t3_rden_pulses", 64'(rden_seen), 64'd3);
        chk("t3_rr_ptr", 64'(dut.r_rr_ptr), 64'd3);
        chk("t3_gnt_cleared", 64'(gnt), 64'd0);
        chk("t3_sb_empty", 64'(sb.size()), 64'd0);

        // Requests while FIFO is empty: stay idle, pointer unchanged
        rden_seen = 0;
        req = 4'b1111;
        repeat (4) tick();
        req = '0;
        chk("t3b_busy", 64'(busy), 64'd0);
        chk("t3b_gnt", 64'(gnt), 64'd0);
        chk("t3b_rr_ptr", 64'(dut.r_rr_ptr), 64'd3);
        chk("t3b_rden", 64'(rden_seen), 64'd0);

        // Requester 1 drops after 2 reads; 3 is next above 1 (0 also waiting)
        rden_seen = 0;
        wr_total += 12;
        push_exp(2'd1, 2);
        push_exp(2'd3, 8);
        req = 4'b0010;
        done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (rden_seen == 2) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) timeout_fail("t4_two_reads");
        @(posedge clk);
        #1;
        req = 4'b1001;
        done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) timeout_fail("t4_drain");
        chk("t4_reads_req1", 64'(rden_seen), 64'd2);
        chk("t4_rr_ptr", 64'(dut.r_rr_ptr), 64'd2);
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt != 4'b0000) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) timeout_fail("t4_regrant");
        chk("t4_next_gnt", 64'(gnt), 64'b1000);
        burst_wait("t4b", 4'b1000);
        req = '0;
        chk("t4_rden_total", 64'(rden_seen), 64'd10);
        chk("t4_sb_empty", 64'(sb.size()), 64'd0);

        // Reset after 3 reads: only the read already delivered is seen
        rden_seen = 0;
        wr_total += 10;
        push_exp(2'd0, 1);
        exp_rd += 2;
        req = 4'b0001;
        done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (rden_seen == 3) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) timeout_fail("t5_three_reads");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_gnt",      64'(gnt),      64'd0);
        chk("t5_rd_valid", 64'(rd_valid), 64'd0);
        chk("t5_rden",     64'(rden),     64'd0);
        chk("t5_regce",    64'(regce),    64'd0);
        chk("t5_busy",     64'(busy),     64'd0);
        chk("t5_rd_tag",   64'(rd_tag),   64'd0);
        req = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) tick();
        chk("t5_no_new_reads", 64'(rden_seen), 64'd3);
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);

        // Error counter saturation
        rderr = 1'b1;
        repeat (100) tick();
        chk("t6_err_100", 64'(err_cnt), 64'd100);
        repeat (200) tick();
        rderr = 1'b0;
        chk("t6_err_sat", 64'(err_cnt), 64'd255);
        tick();
        chk("t6_err_hold", 64'(err_cnt), 64'd255);

        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
